// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: expands one cipher key into
// round keys 0..10, one per clock, and serves them on a read port.
module KeyGeneration (
  input  logic [127:0] key,
  input  logic [3:0]   rc,
  output logic [127:0] keyout
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a_in,
    input logic [7:0] b_in
  );
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b_in[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse (0 maps to 0), then the affine step
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] v;
    sq = x;
    v  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      v  = gmul(v, sq);
    end
    return v
         ^ {v[6:0], v[7]}
         ^ {v[5:0], v[7:6]}
         ^ {v[4:0], v[7:5]}
         ^ {v[3:0], v[7:4]}
         ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, tmp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    unique case (rc)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0  = key[127:96];
  assign w1  = key[95:64];
  assign w2  = key[63:32];
  assign w3  = key[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign tmp = {sbox(rot[31:24]) ^ rcon,
                sbox(rot[23:16]),
                sbox(rot[15:8]),
                sbox(rot[7:0])};
  assign n0  = w0 ^ tmp;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign keyout = {n0, n1, n2, n3};

endmodule

module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [3:0] LAST_RC  = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] MAX_IDX  = 4'(NUM_ROUNDS);

  logic [1:0]   state_q, state_d;
  logic [127:0] cur_q, cur_d;
  logic [3:0]   rc_q, rc_d;
  logic         done_q, done_d;
  logic [127:0] rd_key_q;
  logic [127:0] slot_q [0:NUM_ROUNDS];

  logic         accept;
  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data;
  logic [127:0] keyout;

  KeyGeneration u_kg (
    .key    (cur_q),
    .rc     (rc_q),
    .keyout (keyout)
  );

  assign key_ready  = !rst &&
                      (state_q == S_IDLE ||
                       state_q == S_READY);
  assign accept     = key_valid && key_ready;
  assign busy       = (state_q == S_EXPAND);
  assign keys_ready = (state_q == S_READY);
  assign done       = done_q;
  assign rd_key     = rd_key_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = 4'd0;
    wr_data = keyout;
    unique case (1'b1)
      (state_q == S_EXPAND): begin
        wr_en  = 1'b1;
        wr_idx = rc_q + 4'd1;
        cur_d  = keyout;
        if (rc_q == LAST_RC) begin
          state_d = S_READY;
          done_d  = 1'b1;
          rc_d    = 4'd0;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      (state_q == S_IDLE),
      (state_q == S_READY): begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = key_in;
          cur_d   = key_in;
          rc_d    = 4'd0;
          state_d = S_EXPAND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // read samples the slot before this edge's write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      rc_q     <= '0;
      done_q   <= 1'b0;
      rd_key_q <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++)
        slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      if (rd_idx <= MAX_IDX)
        rd_key_q <= slot_q[rd_idx];
      else
        rd_key_q <= '0;
      if (wr_en)
        slot_q[wr_idx] <= wr_data;
    end
  end

endmodule
